// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer with show-ahead head,
// full back-pressure and a redirect flush that discards every buffered beat.
module if_id_queue #(
  parameter int unsigned               PC_SIZE    = 32,
  parameter int unsigned               INSTR_SIZE = 32,
  parameter int unsigned               DEPTH      = 2,
  parameter logic [INSTR_SIZE-1:0]     NOP_INSTR  = INSTR_SIZE'(32'h0000_0013)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          if_valid,
  input  logic [PC_SIZE-1:0]            if_pc,
  input  logic [INSTR_SIZE-1:0]         if_instr,
  input  logic                          if_take,
  output logic                          if_ready,
  input  logic                          flush,
  output logic                          id_valid,
  output logic [PC_SIZE-1:0]            id_pc,
  output logic [INSTR_SIZE-1:0]         id_instr,
  output logic                          id_take,
  input  logic                          id_ready,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_SIZE-1:0]    pc_mem    [DEPTH];
  logic [INSTR_SIZE-1:0] instr_mem [DEPTH];
  logic                  take_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic push;
  logic pop;

  // Handshake qualifiers; a redirect masks both directions.
  always_comb begin
    if_ready = (cnt != CNT_W'(DEPTH));
    id_valid = (cnt != CNT_W'(0));
    push     = if_valid & if_ready & ~flush;
    pop      = id_valid & id_ready & ~flush;
  end

  // Show-ahead head; invalid head presents a NOP with no prediction.
  always_comb begin
    id_pc    = pc_mem[rd_ptr];
    id_instr = id_valid ? instr_mem[rd_ptr] : NOP_INSTR;
    id_take  = id_valid & take_mem[rd_ptr];
    count    = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage, reset to a NOP image so the idle head is well defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= NOP_INSTR;
        take_mem[i]  <= 1'b0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= if_pc;
      instr_mem[wr_ptr] <= if_instr;
      take_mem[wr_ptr]  <= if_take;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill/back-pressure, streaming wrap,
// flush priority, asynchronous reset and empty-hold behaviour.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_take;
  logic        if_ready;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_take;
  logic        id_ready;
  logic [1:0]  count;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_id_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .if_take  (if_take),
    .if_ready (if_ready),
    .flush    (flush),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_instr (id_instr),
    .id_take  (id_take),
    .id_ready (id_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic tk);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
    if_take  = tk;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; id_ready = 1'b0;
    beat(1'b0, 32'h0, 32'h0, 1'b0);
    #12;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_take",  32'(id_take), 32'd0);
    chk("rst_id_pc",    id_pc, 32'h0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    chk("rst_count",    32'(count), 32'd0);
    rst_n = 1'b1;

    // single beat
    beat(1'b1, 32'h100, 32'h0050_0093, 1'b0);
    tick();
    chk("single_valid", 32'(id_valid), 32'd1);
    chk("single_pc",    id_pc, 32'h100);
    chk("single_instr", id_instr, 32'h0050_0093);
    chk("single_count", 32'(count), 32'd1);
    chk("single_ready", 32'(if_ready), 32'd1);

    // fill to full, then hold a third beat against back-pressure
    beat(1'b1, 32'h104, 32'h0010_0113, 1'b0);
    tick();
    chk("full_count", 32'(count), 32'd2);
    chk("full_ready", 32'(if_ready), 32'd0);
    chk("full_head",  id_pc, 32'h100);
    beat(1'b1, 32'h108, 32'h0020_0193, 1'b0);
    tick();
    chk("held_count", 32'(count), 32'd2);
    chk("held_head",  id_pc, 32'h100);
    id_ready = 1'b1;
    tick();
    chk("pop_full_count", 32'(count), 32'd1);
    chk("pop_full_head",  id_pc, 32'h104);
    chk("pop_full_ready", 32'(if_ready), 32'd1);
    id_ready = 1'b0;
    tick();
    chk("late_push_count", 32'(count), 32'd2);
    chk("late_push_head",  id_pc, 32'h104);
    beat(1'b0, 32'h0, 32'h0, 1'b0);
    id_ready = 1'b1;
    tick();
    chk("drain_head_108", id_pc, 32'h108);
    chk("drain_instr_108", id_instr, 32'h0020_0193);
    tick();
    chk("drain_count", 32'(count), 32'd0);

    // streaming across several pointer wraps
    for (int k = 0; k < 6; k++) begin
      beat(1'b1, 32'h200 + 32'(4 * k), 32'h0000_0093 | (32'(k) << 20), k[0]);
      tick();
      chk("stream_pc",    id_pc, 32'h200 + 32'(4 * k));
      chk("stream_instr", id_instr, 32'h0000_0093 | (32'(k) << 20));
      chk("stream_take",  32'(id_take), 32'(k[0]));
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_ready", 32'(if_ready), 32'd1);
    end
    beat(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("stream_drain", 32'(count), 32'd0);

    // flush with simultaneous push and pop
    id_ready = 1'b0;
    beat(1'b1, 32'h300, 32'h0030_0213, 1'b1);
    tick();
    beat(1'b1, 32'h304, 32'h0040_0293, 1'b0);
    tick();
    chk("preflush_count", 32'(count), 32'd2);
    flush = 1'b1; id_ready = 1'b1;
    beat(1'b1, 32'h308, 32'h0050_0313, 1'b0);
    #1;
    chk("flush_cycle_head", id_pc, 32'h300);
    chk("flush_cycle_take", 32'(id_take), 32'd1);
    tick();
    flush = 1'b0; id_ready = 1'b0;
    beat(1'b0, 32'h0, 32'h0, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_instr", id_instr, NOP);
    chk("flush_take",  32'(id_take), 32'd0);
    beat(1'b1, 32'h400, 32'h0060_0393, 1'b0);
    tick();
    beat(1'b0, 32'h0, 32'h0, 1'b0);
    chk("post_flush_pc",    id_pc, 32'h400);
    chk("post_flush_count", 32'(count), 32'd1);
    tick();
    chk("post_flush_hold", 32'(count), 32'd1);
    id_ready = 1'b1;
    tick();
    chk("post_flush_drain", 32'(count), 32'd0);

    // asynchronous reset with two entries buffered
    id_ready = 1'b0;
    beat(1'b1, 32'h600, 32'h0070_0413, 1'b1);
    tick();
    beat(1'b1, 32'h604, 32'h0080_0493, 1'b0);
    tick();
    beat(1'b0, 32'h0, 32'h0, 1'b0);
    chk("pre_arst_count", 32'(count), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_ready", 32'(if_ready), 32'd1);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_pc",    id_pc, 32'h0);
    chk("arst_instr", id_instr, NOP);
    #1 rst_n = 1'b1;
    beat(1'b1, 32'h500, 32'h0090_0513, 1'b0);
    tick();
    beat(1'b0, 32'h0, 32'h0, 1'b0);
    chk("post_arst_pc",    id_pc, 32'h500);
    chk("post_arst_valid", 32'(id_valid), 32'd1);
    chk("post_arst_count", 32'(count), 32'd1);
    id_ready = 1'b1;
    tick();

    // empty hold
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("empty_valid", 32'(id_valid), 32'd0);
      chk("empty_instr", id_instr, NOP);
      chk("empty_take",  32'(id_take), 32'd0);
      chk("empty_count", 32'(count), 32'd0);
    end
    id_ready = 1'b0;
    beat(1'b1, 32'h700, 32'h00a0_0593, 1'b1);
    tick();
    beat(1'b0, 32'h0, 32'h0, 1'b0);
    chk("after_empty_pc",    id_pc, 32'h700);
    chk("after_empty_instr", id_instr, 32'h00a0_0593);
    chk("after_empty_take",  32'(id_take), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Accepts one fetched (pc, instr, take) beat per cycle and buffers up to DEPTH beats.
- Presents the oldest beat to decode in show-ahead fashion.
- Back-pressures fetch when full.
- Discards all contents on a redirect (branch mispredict or jalr) so that wrong-path instructions never reach decode.

Parameters:
- PC_SIZE, 32, width of program counter.
- INSTR_SIZE, 32, width of instruction word.
- DEPTH, 2, number of entries; power of two, at least 2.
- NOP_INSTR, 32'h00000013, instruction driven to decode when no valid beat is present (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_valid  input  1  fetch presents a beat this cycle.
- if_pc  input  PC_SIZE  pc of fetched instruction.
- if_instr  input  INSTR_SIZE  fetched instruction (already NOP-substituted by fetch).
- if_take  input  1  fetch predicted this instruction taken.
- if_ready  output  1  queue can accept a beat; fetch holds pc when low.
- flush  input  1  redirect (predict_fail OR id_jalr); empties queue.
- id_valid  output  1  head entry valid.
- id_pc  output  PC_SIZE  pc of head entry.
- id_instr  output  INSTR_SIZE  instruction of head entry, or NOP_INSTR when not valid.
- id_take  output  1  take bit of head entry; 0 when not valid.
- id_ready  input  1  decode consumes head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy, for debug and perf counters.

Behaviour:
- **Storage:** DEPTH-entry circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus an occupancy counter cnt in the range 0..DEPTH.
- **Push:** push = if_valid & if_ready & ~flush.
  - Writes {if_pc, if_instr, if_take} at wr_ptr.
  - wr_ptr increments by 1.
- **Pop:** pop = id_valid & id_ready & ~flush. rd_ptr increments by 1.
- **Occupancy:** cnt_next = cnt + push - pop. Push and pop in the same cycle leave cnt unchanged.
- **Ready:** if_ready = (cnt != DEPTH), combinational from registered cnt only.
  - No same-cycle pass-through when full: when full, a pop frees a slot only on the following cycle.
- **Head outputs:** id_valid = (cnt != 0).
  - id_pc/id_instr/id_take read combinationally from the entry at rd_ptr.
  - When cnt==0: id_instr = NOP_INSTR, id_take = 0, id_pc = last-driven storage value (don't care, but stable).
- **Latency:** a beat pushed in cycle N appears at id_* in cycle N+1 if the queue was empty. There is no combinational path from if_* to id_*.
- **Flush:**
  - On the clock edge where flush=1: cnt, wr_ptr and rd_ptr are all set to 0.
  - The incoming beat that cycle is dropped, even if if_valid=1.
  - The head is not counted as consumed, even if id_ready=1.
  - Flush has priority over push and pop.
  - During the flush cycle, id_* still show the pre-flush head. Decode ignores them because it generated or received the same redirect.
- **Empty/full edges:**
  - Pop while cnt==0 is impossible, since id_valid=0.
  - Push while cnt==DEPTH is impossible, since if_ready=0.
  - Protocol violations by the bench (if_valid with if_ready low) are ignored; no state change.
- **Reset (rst_n low, asynchronous):**
  - cnt=0, wr_ptr=0, rd_ptr=0.
  - Storage entries pc=0, instr=NOP_INSTR, take=0.
  - Resulting outputs: id_valid=0, id_instr=NOP_INSTR, id_take=0, id_pc=0, if_ready=1, count=0.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
  - On release, the first push is accepted on the first rising edge with rst_n high.
- **count output:** equals cnt.

Test Plan:
- Reset then single beat: pulse rst_n low, push pc=0x100/instr=0x00500093/take=0, id_ready=0 -> next cycle id_valid=1, id_pc=0x100, id_instr=0x00500093, count=1, if_ready=1.
- Fill to full: push pc=0x100, 0x104 on consecutive cycles with id_ready=0 -> count=2, if_ready=0. A third beat 0x108 held by fetch is not accepted until one cycle after id_ready=1 pops 0x100.
- Streaming: if_valid=1 and id_ready=1 every cycle with pcs 0x200, 0x204, 0x208… -> id_pc follows one cycle behind, count stays 1, if_ready stays 1, order preserved across pointer wrap (more than 4 beats).
- Flush with simultaneous push/pop: queue holds 0x300 (take=1), 0x304; assert flush with if_valid=1 (pc=0x308) and id_ready=1 -> next cycle count=0, id_valid=0, id_instr=0x00000013, id_take=0. Subsequent push 0x400 appears alone at head.
- Async reset mid-stream: with count=2, drop rst_n between clock edges -> id_valid=0, if_ready=1, count=0 before the next edge. After release, push 0x500 appears as head.
- Empty output hold: after draining, id_ready=1 and if_valid=0 for 3 cycles -> id_valid=0, id_instr=0x00000013, id_take=0, count=0, pointers unchanged.
